track_cache_ctrl: RTL and testbench
===================================

TRACK_CACHE_CTRL -- requirements
Module: track_cache_ctrl

Interface
REQ-001 SHALL have parameter SECTORS, default 13, the number of 512-byte SD sectors per track buffer.
REQ-002 SHALL have parameter TRACK_W, default 6, the width of the track number.
REQ-003 SHALL have port clk_sys, input, 1: the single clock for the block.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high.
REQ-005 SHALL have port track, input, TRACK_W: the track requested by the drive logic.
REQ-006 SHALL have port buf_we, input, 1: CPU-side write strobe into the track buffer.
REQ-007 SHALL have port img_mounted, input, 1: one-cycle pulse meaning a new image was mounted.
REQ-008 SHALL have port img_present, input, 1: high when the image size is nonzero.
REQ-009 SHALL have port img_readonly, input, 1: high when write-back to the image is forbidden.
REQ-010 SHALL have port flush_req, input, 1: pulse requesting write-back of a dirty buffer.
REQ-011 SHALL have port sd_lba, output, 32: the sector address.
REQ-012 SHALL have ports sd_rd and sd_wr, output, 1 each: the transfer requests.
REQ-013 SHALL have port sd_ack, input, 1: the transfer acknowledge from hps_io.
REQ-014 SHALL have port track_sec, output, 4: the buffer sector index, which forms the upper buffer address bits.
REQ-015 SHALL have port cpu_wait, output, 1: CPU stall.
REQ-016 SHALL have port busy, output, 1: high whenever the block is not in IDLE.
REQ-017 SHALL have port dirty, output, 1: high when the buffer holds unwritten data.

Function
REQ-018 SHALL implement states IDLE, FLUSH, LOAD and ACKWAIT.
REQ-019 SHALL detect sd_ack edges against a one-cycle registered copy of sd_ack.
REQ-020 In IDLE, the block SHALL give requests this priority: pending mount, then flush_req or a track change with dirty set, then a track change.
  - Track change: track differs from cur_track, or the buffer is not valid.
  - A request is served only if img_present is high; otherwise the block stays in IDLE.
REQ-021 A pending mount SHALL do the following:
  - Clear dirty and valid without write-back.
  - Load `track`.
REQ-022 Dirty with img_readonly high SHALL clear dirty and skip FLUSH.
REQ-023 FLUSH entry SHALL set sd_lba = SECTORS*cur_track (32-bit product), track_sec = 0, sd_wr = 1 and cpu_wait = 1.
REQ-024 LOAD entry SHALL set cur_track = track, sd_lba = SECTORS*track, track_sec = 0, sd_rd = 1 and cpu_wait = 1.
REQ-025 Each sd_ack rise SHALL cause the following:
  - sd_lba increments by 1.
  - If track_sec == SECTORS-1, the active sd_rd/sd_wr drops on the next cycle.
REQ-026 Each sd_ack fall SHALL increment track_sec.
  - If the request is already low, the transfer is complete.
REQ-027 FLUSH completion SHALL clear dirty.
  - If the flush was caused by a track change, the block goes directly to LOAD.
  - Otherwise it goes to IDLE.
REQ-028 LOAD completion SHALL set valid, drop cpu_wait and go to IDLE.
REQ-029 cpu_wait SHALL remain high continuously from FLUSH entry through the end of the following LOAD.
REQ-030 sd_rd and sd_wr SHALL never be high simultaneously.
REQ-031 buf_we high in IDLE with valid set SHALL set dirty.
  - buf_we SHALL be ignored in other states.
REQ-032 img_mounted in any non-IDLE state SHALL set a pending-mount flag.
  - The current transfer completes normally.
  - The mount is serviced in IDLE, and pending-mount clears when that service starts.
REQ-033 track changes SHALL be sampled only in IDLE; intermediate values during an operation are not tracked.
REQ-034 track_sec SHALL wrap from 15 to 0, which is unreachable when SECTORS <= 15.

Reset
REQ-035 Reset SHALL set the following on the next clk_sys edge:
  - sd_rd = sd_wr = cpu_wait = busy = dirty = 0.
  - sd_lba = 0, track_sec = 0, cur_track = 0.
  - valid = 0, pending mount cleared.
REQ-036 After reset, or reset mid-transfer, the block SHALL enter ACKWAIT until sd_ack is observed low, then enter IDLE.
  - Stale ack edges are ignored during this time.

Verification
REQ-037 Scenario: img_present = 1 and track = 5 after reset; sd_ack modelled as 13 high/low pulses.
  - sd_lba = 65..77 is presented.
  - sd_rd falls after the 13th rise.
  - track_sec ends at 13.
  - cpu_wait falls after the 13th ack fall.
  - valid = 1.
REQ-038 Scenario: buf_we in IDLE with track 5 valid, then track changes to 6.
  - FLUSH writes LBAs 65..77, then LOAD reads LBAs 78..90.
  - cpu_wait is continuous throughout; dirty = 0 afterwards.
REQ-039 Scenario: same as REQ-038 but with img_readonly = 1.
  - No sd_wr pulse occurs; LOAD starts directly at LBA 78; dirty = 0.
REQ-040 Scenario: img_mounted pulse during the 4th sector of a LOAD.
  - The LOAD finishes.
  - A new LOAD of the current `track` follows immediately with dirty = 0.
REQ-041 Scenario: reset asserted while sd_ack is high mid-LOAD.
  - sd_rd = 0 on the next cycle.
  - No sd_lba change until sd_ack has gone low.
  - The block then reloads the track.
REQ-042 Scenario: flush_req with dirty = 1 and track unchanged.
  - sd_wr transfers 13 sectors, then the block returns to IDLE with no LOAD.
  - busy falls on the same cycle dirty clears.

Source files
------------

// File: rtl/track_cache_ctrl.sv
// Track buffer controller: keeps one track of the disk image cached in a
// SECTORS*512-byte buffer, writes it back to the SD image when dirty and
// reloads it whenever the drive logic asks for another track.
module track_cache_ctrl #(
    parameter int SECTORS = 13,
    parameter int TRACK_W = 6
) (
    input  logic               clk_sys,
    input  logic               reset,
    input  logic [TRACK_W-1:0] track,
    input  logic               buf_we,
    input  logic               img_mounted,
    input  logic               img_present,
    input  logic               img_readonly,
    input  logic               flush_req,
    output logic [31:0]        sd_lba,
    output logic               sd_rd,
    output logic               sd_wr,
    input  logic               sd_ack,
    output logic [3:0]         track_sec,
    output logic               cpu_wait,
    output logic               busy,
    output logic               dirty
);

    typedef enum logic [1:0] {IDLE, FLUSH, LOAD, ACKWAIT} state_t;

    localparam logic [3:0] LAST_SEC = 4'(SECTORS - 1);

    state_t             state;
    logic               ack_d;
    logic               valid;
    logic               mount_pend;
    logic               load_after;
    logic [TRACK_W-1:0] cur_track;
    logic [TRACK_W-1:0] next_track;

    logic ack_rise;
    logic ack_fall;
    logic track_change;
    logic mount_req;

    // First SD sector of a given track in the image.
    function automatic logic [31:0] track_lba(input logic [TRACK_W-1:0] t);
        return 32'(SECTORS) * 32'(t);
    endfunction

    assign ack_rise     = sd_ack & ~ack_d;
    assign ack_fall     = ~sd_ack & ack_d;
    assign track_change = (track != cur_track) || !valid;
    assign mount_req    = mount_pend | img_mounted;

    // Delayed copy of the acknowledge, used only for edge detection.
    always_ff @(posedge clk_sys) begin
        ack_d <= sd_ack;
    end

    // Main controller: request arbitration in IDLE, sector sequencing in
    // FLUSH/LOAD, and a quiet ACKWAIT that lets a stale ack die out.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state      <= ACKWAIT;
            sd_lba     <= '0;
            sd_rd      <= 1'b0;
            sd_wr      <= 1'b0;
            track_sec  <= '0;
            cpu_wait   <= 1'b0;
            busy       <= 1'b0;
            dirty      <= 1'b0;
            valid      <= 1'b0;
            mount_pend <= 1'b0;
            load_after <= 1'b0;
            cur_track  <= '0;
            next_track <= '0;
        end else begin
            case (state)
                ACKWAIT: begin
                    if (img_mounted) mount_pend <= 1'b1;
                    if (!sd_ack) state <= IDLE;
                end

                IDLE: begin
                    if (img_present && mount_req) begin
                        mount_pend <= 1'b0;
                        dirty      <= 1'b0;
                        valid      <= 1'b0;
                        state      <= LOAD;
                        busy       <= 1'b1;
                        cur_track  <= track;
                        sd_lba     <= track_lba(track);
                        track_sec  <= '0;
                        sd_rd      <= 1'b1;
                        cpu_wait   <= 1'b1;
                    end else if (img_present && dirty && (flush_req || track_change)) begin
                        if (img_readonly) begin
                            dirty <= 1'b0;
                            if (track_change) begin
                                state     <= LOAD;
                                busy      <= 1'b1;
                                cur_track <= track;
                                sd_lba    <= track_lba(track);
                                track_sec <= '0;
                                sd_rd     <= 1'b1;
                                cpu_wait  <= 1'b1;
                            end
                        end else begin
                            state      <= FLUSH;
                            busy       <= 1'b1;
                            load_after <= track_change;
                            next_track <= track;
                            sd_lba     <= track_lba(cur_track);
                            track_sec  <= '0;
                            sd_wr      <= 1'b1;
                            cpu_wait   <= 1'b1;
                        end
                    end else if (img_present && track_change) begin
                        state     <= LOAD;
                        busy      <= 1'b1;
                        cur_track <= track;
                        sd_lba    <= track_lba(track);
                        track_sec <= '0;
                        sd_rd     <= 1'b1;
                        cpu_wait  <= 1'b1;
                    end else begin
                        if (img_mounted) mount_pend <= 1'b1;
                        if (buf_we && valid) dirty <= 1'b1;
                    end
                end

                FLUSH: begin
                    if (img_mounted) mount_pend <= 1'b1;
                    if (ack_rise) begin
                        sd_lba <= sd_lba + 32'd1;
                        if (track_sec == LAST_SEC) sd_wr <= 1'b0;
                    end
                    if (ack_fall) begin
                        track_sec <= track_sec + 4'd1;
                        if (!sd_wr) begin
                            dirty <= 1'b0;
                            if (load_after) begin
                                state     <= LOAD;
                                cur_track <= next_track;
                                sd_lba    <= track_lba(next_track);
                                track_sec <= '0;
                                sd_rd     <= 1'b1;
                            end else begin
                                state    <= IDLE;
                                busy     <= 1'b0;
                                cpu_wait <= 1'b0;
                            end
                        end
                    end
                end

                LOAD: begin
                    if (img_mounted) mount_pend <= 1'b1;
                    if (ack_rise) begin
                        sd_lba <= sd_lba + 32'd1;
                        if (track_sec == LAST_SEC) sd_rd <= 1'b0;
                    end
                    if (ack_fall) begin
                        track_sec <= track_sec + 4'd1;
                        if (!sd_rd) begin
                            valid    <= 1'b1;
                            cpu_wait <= 1'b0;
                            busy     <= 1'b0;
                            state    <= IDLE;
                        end
                    end
                end

                default: state <= ACKWAIT;
            endcase
        end
    end

endmodule

// File: tb/tb_track_cache_ctrl.sv
// Self-checking bench for track_cache_ctrl: an SD host stand-in answers each
// transfer with randomly timed ack pulses, and a track/dirty model predicts
// which sectors must be written back and read in for every operation.
module tb_track_cache_ctrl;

    localparam int SECTORS = 13;
    localparam int TRACK_W = 6;

    logic               clk_sys = 1'b0;
    logic               reset;
    logic [TRACK_W-1:0] track;
    logic               buf_we;
    logic               img_mounted;
    logic               img_present;
    logic               img_readonly;
    logic               flush_req;
    logic [31:0]        sd_lba;
    logic               sd_rd;
    logic               sd_wr;
    logic               sd_ack;
    logic [3:0]         track_sec;
    logic               cpu_wait;
    logic               busy;
    logic               dirty;

    int checks   = 0;
    int failures = 0;

    // Model of the cache contents: which track is held and whether it is dirty.
    int mdl_cur;
    bit mdl_dirty;

    // Outputs captured around the final acknowledge of a transfer.
    logic post_busy;
    logic post_dirty;
    logic post_wait;

    track_cache_ctrl #(.SECTORS(SECTORS), .TRACK_W(TRACK_W)) dut (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .track       (track),
        .buf_we      (buf_we),
        .img_mounted (img_mounted),
        .img_present (img_present),
        .img_readonly(img_readonly),
        .flush_req   (flush_req),
        .sd_lba      (sd_lba),
        .sd_rd       (sd_rd),
        .sd_wr       (sd_wr),
        .sd_ack      (sd_ack),
        .track_sec   (track_sec),
        .cpu_wait    (cpu_wait),
        .busy        (busy),
        .dirty       (dirty)
    );

    // Free-running system clock.
    always #5 clk_sys = ~clk_sys;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // One-cycle pulse on the CPU/mount side inputs, starting at a negedge.
    task automatic applyStimulus(input bit we, input bit flush, input bit mount);
        buf_we      = we;
        flush_req   = flush;
        img_mounted = mount;
        @(negedge clk_sys);
        buf_we      = 1'b0;
        flush_req   = 1'b0;
        img_mounted = 1'b0;
    endtask

    // One sector handshake with random high/low lengths.
    task automatic ack_pulse(input logic [31:0] exp_lba, input int idx, input bit is_wr, input bit mount);
        bit last;
        int lo;
        last = (idx == SECTORS - 1);
        checkOutput("lba_presented", sd_lba, exp_lba);
        checkOutput("track_sec", 32'(track_sec), idx);
        checkOutput("cpu_wait_xfer", 32'(cpu_wait), 1);
        checkOutput("dirty_xfer", 32'(dirty), 32'(is_wr));
        checkOutput("req_active", 32'(is_wr ? sd_wr : sd_rd), 1);
        checkOutput("req_exclusive", 32'(is_wr ? sd_rd : sd_wr), 0);
        sd_ack      = 1'b1;
        img_mounted = mount;
        repeat ($urandom_range(3, 1)) begin
            @(negedge clk_sys);
            img_mounted = 1'b0;
        end
        checkOutput("lba_after_rise", sd_lba, exp_lba + 32'd1);
        checkOutput("req_after_rise", 32'(is_wr ? sd_wr : sd_rd), last ? 0 : 1);
        if (last) begin
            checkOutput("busy_before_done", 32'(busy), 1);
            checkOutput("dirty_before_done", 32'(dirty), 32'(is_wr));
        end
        sd_ack = 1'b0;
        lo = $urandom_range(3, 1);
        @(negedge clk_sys);
        if (last) begin
            post_busy  = busy;
            post_dirty = dirty;
            post_wait  = cpu_wait;
        end
        repeat (lo - 1) begin
            @(negedge clk_sys);
            if (last) post_wait = post_wait & cpu_wait;
        end
    endtask

    // Wait (bounded) for a request, then serve all sectors of the track.
    task automatic serve(input bit is_wr, input logic [31:0] start_lba, input int mount_sec, input bit must_wait);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 30; k++) begin
            checkOutput("no_other_req", 32'(is_wr ? sd_rd : sd_wr), 0);
            if (must_wait) checkOutput("wait_between", 32'(cpu_wait), 1);
            if (is_wr ? sd_wr : sd_rd) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk_sys);
        end
        checkOutput(is_wr ? "wr_start" : "rd_start", 32'(seen), 1);
        if (seen) begin
            for (int i = 0; i < SECTORS; i++) begin
                ack_pulse(start_lba + 32'(i), i, is_wr, i == mount_sec);
            end
        end
    endtask

    task automatic mark_dirty();
        applyStimulus(1'b1, 1'b0, 1'b0);
        mdl_dirty = 1'b1;
        checkOutput("dirty_set", 32'(dirty), 1);
    endtask

    // Move to a new track; a dirty writable buffer is written back first.
    task automatic change_track(input int t, input bit ro);
        bit wb;
        wb = mdl_dirty && !ro;
        img_readonly = ro;
        track = TRACK_W'(t);
        if (wb) begin
            serve(1'b1, 32'(SECTORS * mdl_cur), -1, 1'b0);
            checkOutput("flush_dirty_clear", 32'(post_dirty), 0);
            checkOutput("wait_continuous", 32'(post_wait), 1);
        end
        serve(1'b0, 32'(SECTORS * t), -1, wb);
        mdl_dirty = 1'b0;
        mdl_cur   = t;
        checkOutput("load_done_wait", 32'(post_wait), 0);
        checkOutput("load_done_busy", 32'(post_busy), 0);
        checkOutput("dirty_after_load", 32'(dirty), 0);
        img_readonly = 1'b0;
    endtask

    // Explicit flush request with the track unchanged: never a LOAD.
    task automatic do_flush(input bit ro);
        img_readonly = ro;
        applyStimulus(1'b0, 1'b1, 1'b0);
        if (mdl_dirty && !ro) begin
            serve(1'b1, 32'(SECTORS * mdl_cur), -1, 1'b0);
            checkOutput("flush_busy_fall", 32'(post_busy), 0);
            checkOutput("flush_dirty_fall", 32'(post_dirty), 0);
        end
        repeat (6) begin
            @(negedge clk_sys);
            checkOutput("no_load_after_flush", 32'(sd_rd | sd_wr), 0);
        end
        mdl_dirty = 1'b0;
        checkOutput("dirty_after_flush", 32'(dirty), 0);
        checkOutput("busy_after_flush", 32'(busy), 0);
        img_readonly = 1'b0;
    endtask

    // Directed scenarios followed by a randomized sequence of operations.
    initial begin
        bit seen;
        reset        = 1'b1;
        track        = '0;
        buf_we       = 1'b0;
        img_mounted  = 1'b0;
        img_present  = 1'b0;
        img_readonly = 1'b0;
        flush_req    = 1'b0;
        sd_ack       = 1'b0;
        mdl_cur      = 0;
        mdl_dirty    = 1'b0;
        post_busy    = 1'b0;
        post_dirty   = 1'b0;
        post_wait    = 1'b0;
        repeat (3) @(negedge clk_sys);

        checkOutput("rst_sd_rd", 32'(sd_rd), 0);
        checkOutput("rst_sd_wr", 32'(sd_wr), 0);
        checkOutput("rst_cpu_wait", 32'(cpu_wait), 0);
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_dirty", 32'(dirty), 0);
        checkOutput("rst_sd_lba", sd_lba, 0);
        checkOutput("rst_track_sec", 32'(track_sec), 0);

        // No image: the block must stay idle.
        track = TRACK_W'(5);
        reset = 1'b0;
        repeat (6) @(negedge clk_sys);
        checkOutput("no_image_rd", 32'(sd_rd), 0);
        checkOutput("no_image_busy", 32'(busy), 0);

        // Initial load of track 5: LBAs 65..77.
        img_present = 1'b1;
        serve(1'b0, 32'(SECTORS * 5), -1, 1'b0);
        mdl_cur = 5;
        checkOutput("first_load_track_sec", 32'(track_sec), SECTORS);
        checkOutput("first_load_wait", 32'(post_wait), 0);
        repeat (4) begin
            @(negedge clk_sys);
            checkOutput("valid_no_reload", 32'(sd_rd), 0);
        end

        // Dirty buffer then track change: write back 65..77, read 78..90.
        mark_dirty();
        change_track(6, 1'b0);

        // Same with a read-only image: no write-back.
        mark_dirty();
        change_track(7, 1'b1);

        // Mount during the 4th sector of a LOAD: reload follows.
        track = TRACK_W'(9);
        serve(1'b0, 32'(SECTORS * 9), 3, 1'b0);
        serve(1'b0, 32'(SECTORS * 9), -1, 1'b0);
        mdl_cur = 9;
        checkOutput("mount_reload_dirty", 32'(dirty), 0);

        // Mount while dirty in IDLE discards the data without write-back.
        mark_dirty();
        applyStimulus(1'b0, 1'b0, 1'b1);
        serve(1'b0, 32'(SECTORS * 9), -1, 1'b0);
        mdl_dirty = 1'b0;
        checkOutput("mount_discard_dirty", 32'(dirty), 0);

        // Explicit flush, track unchanged.
        mark_dirty();
        do_flush(1'b0);

        // Reset while the ack is high in the middle of a LOAD.
        track = TRACK_W'(12);
        seen = 1'b0;
        for (int k = 0; k < 30; k++) begin
            if (sd_rd) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk_sys);
        end
        checkOutput("rst_case_rd_start", 32'(seen), 1);
        for (int i = 0; i < 3; i++) ack_pulse(32'(SECTORS * 12 + i), i, 1'b0, 1'b0);
        sd_ack = 1'b1;
        @(negedge clk_sys);
        reset = 1'b1;
        @(negedge clk_sys);
        checkOutput("midrst_sd_rd", 32'(sd_rd), 0);
        checkOutput("midrst_busy", 32'(busy), 0);
        checkOutput("midrst_cpu_wait", 32'(cpu_wait), 0);
        checkOutput("midrst_track_sec", 32'(track_sec), 0);
        reset = 1'b0;
        repeat (4) begin
            @(negedge clk_sys);
            checkOutput("ackwait_lba_hold", sd_lba, 0);
            checkOutput("ackwait_no_rd", 32'(sd_rd), 0);
        end
        sd_ack = 1'b0;
        serve(1'b0, 32'(SECTORS * 12), -1, 1'b0);
        mdl_cur   = 12;
        mdl_dirty = 1'b0;

        // Randomized operations against the model.
        for (int n = 0; n < 10; n++) begin
            int op;
            int t;
            bit ro;
            op = int'($urandom_range(2, 0));
            ro = 1'($urandom_range(1, 0));
            do t = int'($urandom_range(2**TRACK_W - 1, 0)); while (t == mdl_cur);
            case (op)
                0: begin mark_dirty(); change_track(t, ro); end
                1: change_track(t, 1'b0);
                default: begin mark_dirty(); do_flush(ro); end
            endcase
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
